// File: rtl/flash_arb_pkg.sv
// Shared types for the flash phy arbiter: phy op codes, arbiter states and requester ids.
package flash_arb_pkg;

  typedef enum logic [1:0] {
    FlashOpRead  = 2'd0,
    FlashOpProg  = 2'd1,
    FlashOpErase = 2'd2,
    FlashOpRsvd  = 2'd3
  } flash_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHost = 2'd1,
    StCtrl = 2'd2
  } arb_st_e;

  typedef enum logic {
    Host = 1'b0,
    Ctrl = 1'b1
  } requester_e;

endpackage

// File: rtl/flash_arb_rr.sv
// Two-way round-robin picker: one-hot grant (bit0 host, bit1 ctrl), purely combinational.
// A tie goes to the requester opposite last_gnt; nothing is granted while en is low.
module flash_arb_rr
  import flash_arb_pkg::*;
(
  input  logic       en,
  input  logic [1:0] reqs,
  input  requester_e last_gnt,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (reqs)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_gnt == Host) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/flash_phy_arb.sv
// Shares the flash phy between host reads and controller ops, one transaction at a time; grant in cycle 0, phy req from cycle 1, response one cycle after phy done.
// Requesters hold req until gnt; optional watchdog FLASH_ARB_TIMEOUT_EN aborts a stuck phy after TimeoutCycles busy cycles.
module flash_phy_arb
  import flash_arb_pkg::*;
#(
  parameter int unsigned AddrW         = 10,
  parameter int unsigned DataW         = 32,
  parameter int unsigned TimeoutCycles = 1023
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             host_req_i,
  input  logic [AddrW-1:0] host_addr_i,
  output logic             host_gnt_o,
  output logic             host_rvalid_o,
  output logic [DataW-1:0] host_rdata_o,
  output logic             host_err_o,
  input  logic             ctrl_req_i,
  input  logic [1:0]       ctrl_op_i,
  input  logic [AddrW-1:0] ctrl_addr_i,
  input  logic [DataW-1:0] ctrl_wdata_i,
  output logic             ctrl_gnt_o,
  output logic             ctrl_done_o,
  output logic [DataW-1:0] ctrl_rdata_o,
  output logic             ctrl_err_o,
  output logic             flash_req_o,
  output logic [1:0]       flash_op_o,
  output logic [AddrW-1:0] flash_addr_o,
  output logic [DataW-1:0] flash_wdata_o,
  input  logic [DataW-1:0] flash_rdata_i,
  input  logic             flash_done_i,
  input  logic             flash_error_i
);

  arb_st_e          state_q, state_d;
  requester_e       last_gnt_q;
  flash_op_e        op_q;
  logic [AddrW-1:0] addr_q;
  logic [DataW-1:0] wdata_q;
  logic [1:0]       gnt;
  logic             resp_fire, resp_err, timeout_hit;
  logic [DataW-1:0] resp_rdata;
  logic             host_rvalid_q, host_err_q, ctrl_done_q, ctrl_err_q;
  logic [DataW-1:0] host_rdata_q, ctrl_rdata_q;

  flash_arb_rr u_rr (
    .en       (state_q == StIdle),
    .reqs     ({ctrl_req_i, host_req_i}),
    .last_gnt (last_gnt_q),
    .gnt      (gnt)
  );

`ifdef FLASH_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] tmo_cnt_q;

  // Held at zero while idle, so every transaction starts counting from 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt_q <= '0;
    end else if (state_q == StIdle) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + CntW'(1);
    end
  end

  assign timeout_hit = (tmo_cnt_q == CntW'(TimeoutCycles - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TimeoutCycles;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    resp_fire  = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    case (state_q)
      StIdle: begin
        if (gnt[0])      state_d = StHost;
        else if (gnt[1]) state_d = StCtrl;
      end
      StHost, StCtrl: begin
        // Reserved ops never reach the phy; they complete at once with an error.
        if (state_q == StCtrl && op_q == FlashOpRsvd) begin
          state_d   = StIdle;
          resp_fire = 1'b1;
          resp_err  = 1'b1;
        end else if (flash_done_i) begin
          state_d    = StIdle;
          resp_fire  = 1'b1;
          resp_err   = flash_error_i;
          resp_rdata = flash_rdata_i;
        end else if (timeout_hit) begin
          state_d    = StIdle;
          resp_fire  = 1'b1;
          resp_err   = 1'b1;
          resp_rdata = '1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      last_gnt_q    <= Ctrl;
      op_q          <= FlashOpRead;
      addr_q        <= '0;
      wdata_q       <= '0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
      host_err_q    <= 1'b0;
      ctrl_done_q   <= 1'b0;
      ctrl_rdata_q  <= '0;
      ctrl_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      host_rvalid_q <= resp_fire && (state_q == StHost);
      ctrl_done_q   <= resp_fire && (state_q == StCtrl);
      if (gnt[0]) begin
        last_gnt_q <= Host;
        op_q       <= FlashOpRead;
        addr_q     <= host_addr_i;
        wdata_q    <= '0;
      end else if (gnt[1]) begin
        last_gnt_q <= Ctrl;
        op_q       <= flash_op_e'(ctrl_op_i);
        addr_q     <= ctrl_addr_i;
        wdata_q    <= ctrl_wdata_i;
      end
      if (resp_fire && state_q == StHost) begin
        host_rdata_q <= resp_rdata;
        host_err_q   <= resp_err;
      end
      if (resp_fire && state_q == StCtrl) begin
        ctrl_rdata_q <= resp_rdata;
        ctrl_err_q   <= resp_err;
      end
    end
  end

  assign host_gnt_o    = gnt[0];
  assign ctrl_gnt_o    = gnt[1];
  assign host_rvalid_o = host_rvalid_q;
  assign host_rdata_o  = host_rdata_q;
  assign host_err_o    = host_err_q;
  assign ctrl_done_o   = ctrl_done_q;
  assign ctrl_rdata_o  = ctrl_rdata_q;
  assign ctrl_err_o    = ctrl_err_q;
  assign flash_req_o   = (state_q == StHost) || (state_q == StCtrl && op_q != FlashOpRsvd);
  assign flash_op_o    = op_q;
  assign flash_addr_o  = addr_q;
  assign flash_wdata_o = wdata_q;

endmodule

// File: tb/tb_flash_phy_arb.sv
// Directed bench for flash_phy_arb: inputs change 1ns after posedge, outputs sampled on negedge.
module tb_flash_phy_arb;

  localparam int unsigned TO = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        host_req_i;
  logic [9:0]  host_addr_i;
  logic        host_gnt_o, host_rvalid_o, host_err_o;
  logic [31:0] host_rdata_o;
  logic        ctrl_req_i;
  logic [1:0]  ctrl_op_i;
  logic [9:0]  ctrl_addr_i;
  logic [31:0] ctrl_wdata_i;
  logic        ctrl_gnt_o, ctrl_done_o, ctrl_err_o;
  logic [31:0] ctrl_rdata_o;
  logic        flash_req_o;
  logic [1:0]  flash_op_o;
  logic [9:0]  flash_addr_o;
  logic [31:0] flash_wdata_o;
  logic [31:0] flash_rdata_i;
  logic        flash_done_i, flash_error_i;

  logic [114:0] all_out;
  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  assign all_out = {host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
                    ctrl_gnt_o, ctrl_done_o, ctrl_rdata_o, ctrl_err_o,
                    flash_req_o, flash_op_o, flash_addr_o, flash_wdata_o};

  flash_phy_arb #(.AddrW(10), .DataW(32), .TimeoutCycles(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .host_req_i(host_req_i), .host_addr_i(host_addr_i), .host_gnt_o(host_gnt_o),
    .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
    .ctrl_req_i(ctrl_req_i), .ctrl_op_i(ctrl_op_i), .ctrl_addr_i(ctrl_addr_i),
    .ctrl_wdata_i(ctrl_wdata_i), .ctrl_gnt_o(ctrl_gnt_o), .ctrl_done_o(ctrl_done_o),
    .ctrl_rdata_o(ctrl_rdata_o), .ctrl_err_o(ctrl_err_o),
    .flash_req_o(flash_req_o), .flash_op_o(flash_op_o), .flash_addr_o(flash_addr_o),
    .flash_wdata_o(flash_wdata_o), .flash_rdata_i(flash_rdata_i),
    .flash_done_i(flash_done_i), .flash_error_i(flash_error_i)
  );

  task automatic next_cycle;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk_i);
    total++;
    if (all_out !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", all_out);
    end
    next_cycle();
    rst_ni = 1'b1;
    @(negedge clk_i);
    total++;
    if (all_out !== '0) begin
      bad++;
      $display("FAIL idle_after_reset got=%h want=0", all_out);
    end
  endtask

  task automatic test_host_read;
    next_cycle();
    host_req_i  = 1'b1;
    host_addr_i = 10'h12A;
    @(negedge clk_i);
    total++;
    if ({host_gnt_o, ctrl_gnt_o, flash_req_o} !== 3'b100) begin
      bad++;
      $display("FAIL host_gnt got=%b want=100", {host_gnt_o, ctrl_gnt_o, flash_req_o});
    end
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      host_req_i  = 1'b0;
      host_addr_i = 10'h000;
      if (c == 3) begin
        flash_done_i  = 1'b1;
        flash_rdata_i = 32'hDEADBEEF;
      end
      @(negedge clk_i);
      total++;
      if (flash_req_o !== 1'b1 || flash_addr_o !== 10'h12A || flash_op_o !== 2'd0 ||
          flash_wdata_o !== 32'h0 || host_gnt_o !== 1'b0) begin
        bad++;
        $display("FAIL host_busy c=%0d req=%b addr=%h op=%0d wdata=%h gnt=%b want req=1 addr=12a op=0 wdata=0 gnt=0",
                 c, flash_req_o, flash_addr_o, flash_op_o, flash_wdata_o, host_gnt_o);
      end
    end
    next_cycle();
    flash_done_i  = 1'b0;
    flash_rdata_i = 32'h0;
    @(negedge clk_i);
    total++;
    if (host_rvalid_o !== 1'b1 || host_rdata_o !== 32'hDEADBEEF || host_err_o !== 1'b0 ||
        flash_req_o !== 1'b0 || ctrl_done_o !== 1'b0) begin
      bad++;
      $display("FAIL host_resp rvalid=%b rdata=%h err=%b req=%b done=%b want 1 deadbeef 0 0 0",
               host_rvalid_o, host_rdata_o, host_err_o, flash_req_o, ctrl_done_o);
    end
    next_cycle();
    @(negedge clk_i);
    total++;
    if (host_rvalid_o !== 1'b0 || host_rdata_o !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL host_resp_pulse rvalid=%b rdata=%h want 0 deadbeef", host_rvalid_o, host_rdata_o);
    end
  endtask

  task automatic test_back_to_back;
    int ng;
    next_cycle();
    rst_ni = 1'b0;
    #2;
    rst_ni = 1'b1;
    next_cycle();
    host_req_i  = 1'b1;
    host_addr_i = 10'h040;
    ctrl_req_i  = 1'b1;
    ctrl_op_i   = 2'd0;
    ctrl_addr_i = 10'h080;
    ng = 0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) begin
        next_cycle();
        flash_done_i  = flash_req_o;
        flash_rdata_i = 32'(c);
        if (ng >= 4) begin
          host_req_i = 1'b0;
          ctrl_req_i = 1'b0;
        end
      end
      @(negedge clk_i);
      total++;
      if (host_gnt_o === 1'b1 && ctrl_gnt_o === 1'b1) begin
        bad++;
        $display("FAIL b2b_two_gnt cycle=%0d got both grants want at most one", c);
      end
      if (host_gnt_o === 1'b1 || ctrl_gnt_o === 1'b1) begin
        total++;
        if (flash_req_o !== 1'b0) begin
          bad++;
          $display("FAIL b2b_gap cycle=%0d flash_req=%b want 0", c, flash_req_o);
        end
        if (ng < 4) begin
          total++;
          if (ctrl_gnt_o !== ng[0]) begin
            bad++;
            $display("FAIL b2b_order n=%0d ctrl_gnt=%b want %b", ng, ctrl_gnt_o, ng[0]);
          end
        end
        ng++;
      end
    end
    flash_done_i = 1'b0;
    total++;
    if (ng !== 4) begin
      bad++;
      $display("FAIL b2b_count grants=%0d want 4", ng);
    end
  endtask

  task automatic test_ctrl_prog_err;
    next_cycle();
    ctrl_req_i   = 1'b1;
    ctrl_op_i    = 2'd1;
    ctrl_addr_i  = 10'h3FF;
    ctrl_wdata_i = 32'hA5A5A5A5;
    @(negedge clk_i);
    total++;
    if ({host_gnt_o, ctrl_gnt_o} !== 2'b01) begin
      bad++;
      $display("FAIL prog_gnt got=%b want 01", {host_gnt_o, ctrl_gnt_o});
    end
    for (int c = 1; c <= 2; c++) begin
      next_cycle();
      ctrl_req_i   = 1'b0;
      ctrl_op_i    = 2'd0;
      ctrl_addr_i  = 10'h000;
      ctrl_wdata_i = 32'h0;
      if (c == 2) begin
        flash_done_i  = 1'b1;
        flash_error_i = 1'b1;
        flash_rdata_i = 32'h11223344;
      end
      @(negedge clk_i);
      total++;
      if (flash_req_o !== 1'b1 || flash_op_o !== 2'd1 || flash_addr_o !== 10'h3FF ||
          flash_wdata_o !== 32'hA5A5A5A5) begin
        bad++;
        $display("FAIL prog_busy c=%0d req=%b op=%0d addr=%h wdata=%h want 1 1 3ff a5a5a5a5",
                 c, flash_req_o, flash_op_o, flash_addr_o, flash_wdata_o);
      end
    end
    next_cycle();
    flash_done_i  = 1'b0;
    flash_error_i = 1'b0;
    @(negedge clk_i);
    total++;
    if (ctrl_done_o !== 1'b1 || ctrl_err_o !== 1'b1 || ctrl_rdata_o !== 32'h11223344 ||
        host_rvalid_o !== 1'b0) begin
      bad++;
      $display("FAIL prog_resp done=%b err=%b rdata=%h rvalid=%b want 1 1 11223344 0",
               ctrl_done_o, ctrl_err_o, ctrl_rdata_o, host_rvalid_o);
    end
  endtask

  task automatic test_rsvd;
    next_cycle();
    ctrl_req_i  = 1'b1;
    ctrl_op_i   = 2'd3;
    ctrl_addr_i = 10'h011;
    @(negedge clk_i);
    total++;
    if (ctrl_gnt_o !== 1'b1 || flash_req_o !== 1'b0) begin
      bad++;
      $display("FAIL rsvd_gnt gnt=%b req=%b want 1 0", ctrl_gnt_o, flash_req_o);
    end
    next_cycle();
    ctrl_req_i = 1'b0;
    ctrl_op_i  = 2'd0;
    @(negedge clk_i);
    total++;
    if (flash_req_o !== 1'b0 || ctrl_done_o !== 1'b0) begin
      bad++;
      $display("FAIL rsvd_c1 req=%b done=%b want 0 0", flash_req_o, ctrl_done_o);
    end
    next_cycle();
    @(negedge clk_i);
    total++;
    if (ctrl_done_o !== 1'b1 || ctrl_err_o !== 1'b1 || flash_req_o !== 1'b0) begin
      bad++;
      $display("FAIL rsvd_done done=%b err=%b req=%b want 1 1 0", ctrl_done_o, ctrl_err_o, flash_req_o);
    end
    next_cycle();
    @(negedge clk_i);
    total++;
    if (ctrl_done_o !== 1'b0) begin
      bad++;
      $display("FAIL rsvd_pulse done=%b want 0", ctrl_done_o);
    end
  endtask

  task automatic test_reset_mid;
    next_cycle();
    host_req_i  = 1'b1;
    host_addr_i = 10'h0AA;
    @(negedge clk_i);
    total++;
    if (host_gnt_o !== 1'b1) begin
      bad++;
      $display("FAIL rmid_gnt got=%b want 1", host_gnt_o);
    end
    next_cycle();
    host_req_i = 1'b0;
    next_cycle();
    rst_ni = 1'b0;
    #1;
    total++;
    if (all_out !== '0) begin
      bad++;
      $display("FAIL rmid_outputs got=%h want 0", all_out);
    end
    next_cycle();
    rst_ni        = 1'b1;
    flash_done_i  = 1'b1;
    flash_rdata_i = 32'h0BAD0BAD;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      total++;
      if (host_rvalid_o !== 1'b0 || ctrl_done_o !== 1'b0 || flash_req_o !== 1'b0) begin
        bad++;
        $display("FAIL rmid_quiet c=%0d rvalid=%b done=%b req=%b want 0 0 0",
                 c, host_rvalid_o, ctrl_done_o, flash_req_o);
      end
      next_cycle();
      flash_done_i = 1'b0;
    end
    host_req_i  = 1'b1;
    host_addr_i = 10'h155;
    ctrl_req_i  = 1'b1;
    ctrl_op_i   = 2'd0;
    @(negedge clk_i);
    total++;
    if ({host_gnt_o, ctrl_gnt_o} !== 2'b10) begin
      bad++;
      $display("FAIL rmid_tie got=%b want 10", {host_gnt_o, ctrl_gnt_o});
    end
    next_cycle();
    host_req_i    = 1'b0;
    ctrl_req_i    = 1'b0;
    flash_done_i  = 1'b1;
    flash_rdata_i = 32'h00000005;
    next_cycle();
    flash_done_i = 1'b0;
    @(negedge clk_i);
    total++;
    if (host_rvalid_o !== 1'b1 || host_rdata_o !== 32'h5 || ctrl_done_o !== 1'b0) begin
      bad++;
      $display("FAIL rmid_resp rvalid=%b rdata=%h done=%b want 1 5 0", host_rvalid_o, host_rdata_o, ctrl_done_o);
    end
  endtask

`ifdef FLASH_ARB_TIMEOUT_EN
  task automatic test_timeout;
    int busy;
    next_cycle();
    host_req_i  = 1'b1;
    host_addr_i = 10'h200;
    busy = 0;
    for (int c = 1; c < 40; c++) begin
      next_cycle();
      host_req_i = 1'b0;
      @(negedge clk_i);
      if (flash_req_o !== 1'b1) break;
      busy++;
    end
    total++;
    if (busy !== int'(TO)) begin
      bad++;
      $display("FAIL tmo_busy cycles=%0d want %0d", busy, TO);
    end
    total++;
    if (host_rvalid_o !== 1'b1 || host_err_o !== 1'b1 || host_rdata_o !== 32'hFFFFFFFF) begin
      bad++;
      $display("FAIL tmo_resp rvalid=%b err=%b rdata=%h want 1 1 ffffffff", host_rvalid_o, host_err_o, host_rdata_o);
    end
  endtask
`endif

  initial begin
    rst_ni        = 1'b0;
    host_req_i    = 1'b0;
    host_addr_i   = '0;
    ctrl_req_i    = 1'b0;
    ctrl_op_i     = '0;
    ctrl_addr_i   = '0;
    ctrl_wdata_i  = '0;
    flash_rdata_i = '0;
    flash_done_i  = 1'b0;
    flash_error_i = 1'b0;
    test_reset();
    test_host_read();
    test_back_to_back();
    test_ctrl_prog_err();
    test_rsvd();
    test_reset_mid();
`ifdef FLASH_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
